// File: rtl/timersoc_gpio_out.sv
// Avalon-MM GPIO output block: DATA register with set/clear/toggle aliases,
// plus a one-shot pulse engine that inverts PMASK bits for N cycles.
module timersoc_gpio_out #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned RESET_VALUE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  typedef enum logic {IDLE, PULSING} state_t;

  localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(RESET_VALUE);

  state_t           state_q, state_d;
  logic [15:0]      rem_q, rem_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] pmask_q, pmask_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [31:0]      rd_q, rd_d;

  logic             wr_en, rd_en, trig;
  logic [WIDTH-1:0] wd;
  logic             unused_wd_hi;

  assign wr_en        = chipselect & ~write_n;
  assign rd_en        = chipselect & write_n;
  assign trig         = wr_en && (address == 3'd3);
  assign wd           = writedata[WIDTH-1:0];
  assign unused_wd_hi = ^writedata[31:16];

  always_comb begin
    data_d  = data_q;
    pmask_d = pmask_q;
    if (wr_en) begin
      case (address)
        3'd0:    data_d  = wd;
        3'd1:    data_d  = data_q ^ wd;
        3'd2:    pmask_d = wd;
        3'd4:    data_d  = data_q | wd;
        3'd5:    data_d  = data_q & ~wd;
        default: ;
      endcase
    end
  end

  // A trigger write outranks the decrement, giving retrigger and abort
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    if (trig) begin
      if (writedata[15:0] != 16'd0) begin
        rem_d   = writedata[15:0];
        state_d = PULSING;
      end else begin
        rem_d   = '0;
        state_d = IDLE;
      end
    end else if (state_q == PULSING) begin
      rem_d = rem_q - 16'd1;
      if (rem_q == 16'd1) state_d = IDLE;
    end
  end

  always_comb begin
    rd_d = rd_q;
    if (rd_en) begin
      case (address)
        3'd0:    rd_d = {{(32-WIDTH){1'b0}}, data_q};
        3'd2:    rd_d = {{(32-WIDTH){1'b0}}, pmask_q};
        3'd3:    rd_d = {15'b0, (state_q == PULSING), rem_q};
        default: rd_d = '0;
      endcase
    end
  end

  assign out_d = data_d ^ ((state_d == PULSING) ? pmask_d : '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      rem_q   <= '0;
      data_q  <= RST_VAL;
      pmask_q <= '0;
      out_q   <= RST_VAL;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      data_q  <= data_d;
      pmask_q <= pmask_d;
      out_q   <= out_d;
      rd_q    <= rd_d;
    end
  end

  assign readdata = rd_q;
  assign out_port = out_q;

endmodule

// File: tb/tb_timersoc_gpio_out.sv
// Bench for timersoc_gpio_out: directed scenarios plus randomized traffic
// checked against a pulse-end-time reference model.
module tb_timersoc_gpio_out;

  localparam int unsigned W  = 8;
  localparam logic [7:0]  RV = 8'h3C;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [2:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic [W-1:0] out_port;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: a pulse is a window of edge indices [start, pend)
  int         cyc = 0;
  int         pend = 0;
  logic [7:0] m_data = RV;
  logic [7:0] m_pmask = '0;
  logic [7:0] m_out = RV;
  logic [31:0] m_rd = '0;

  timersoc_gpio_out #(.WIDTH(W), .RESET_VALUE(RV)) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .out_port(out_port)
  );

  always #5 clk = ~clk;

  task automatic model_step(input logic rst, input logic cs, input logic wn,
                            input logic [2:0] a, input logic [31:0] wdat);
    int e;
    logic busy_old;
    int rem_old;
    cyc++;
    e = cyc;
    busy_old = (e - 1) < pend;
    rem_old  = busy_old ? pend - (e - 1) : 0;
    if (rst) begin
      m_data = RV; m_pmask = '0; pend = 0; m_rd = '0; m_out = RV;
      return;
    end
    if (cs && wn) begin
      if (a == 3'd0)      m_rd = 32'(m_data);
      else if (a == 3'd2) m_rd = 32'(m_pmask);
      else if (a == 3'd3) m_rd = (busy_old ? 32'h1_0000 : 32'h0) + 32'(rem_old);
      else                m_rd = 32'h0;
    end
    if (cs && !wn) begin
      case (a)
        3'd0: m_data = wdat[7:0];
        3'd1: m_data = m_data ^ wdat[7:0];
        3'd2: m_pmask = wdat[7:0];
        3'd3: pend = (wdat[15:0] != 16'd0) ? e + int'(wdat[15:0]) : 0;
        3'd4: m_data = m_data | wdat[7:0];
        3'd5: m_data = m_data & ~wdat[7:0];
        default: ;
      endcase
    end
    m_out = m_data ^ ((e < pend) ? m_pmask : 8'h00);
  endtask

  task automatic drive(input logic rst, input logic cs, input logic wn,
                       input logic [2:0] a, input logic [31:0] wdat);
    reset = rst; chipselect = cs; write_n = wn; address = a; writedata = wdat;
    @(posedge clk);
    model_step(rst, cs, wn, a, wdat);
    #1;
    reset = 1'b0; chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d); drive(1'b0, 1'b1, 1'b0, a, d); endtask
  task automatic rd(input logic [2:0] a); drive(1'b0, 1'b1, 1'b1, a, 32'h0); endtask
  task automatic idle(); drive(1'b0, 1'b0, 1'b1, 3'd0, 32'h0); endtask

  task automatic test_reset();
    drive(1'b1, 1'b1, 1'b0, 3'd0, 32'hFF);  // reset wins over a coincident write
    n_vec++; if (out_port !== RV) begin n_err++; $display("FAIL reset_out: got %h expected %h", out_port, RV); end
    n_vec++; if (readdata !== 32'h0) begin n_err++; $display("FAIL reset_rd: got %h expected %h", readdata, 32'h0); end
    rd(3'd3);
    n_vec++; if (readdata !== 32'h0) begin n_err++; $display("FAIL reset_status: got %h expected %h", readdata, 32'h0); end
    rd(3'd0);
    n_vec++; if (readdata !== 32'h3C) begin n_err++; $display("FAIL reset_data: got %h expected %h", readdata, 32'h3C); end
  endtask

  task automatic test_data_rw();
    wr(3'd0, 32'hFFFF_FFA5);
    n_vec++; if (out_port !== 8'hA5) begin n_err++; $display("FAIL data_out: got %h expected %h", out_port, 8'hA5); end
    rd(3'd0);
    n_vec++; if (readdata !== 32'h0000_00A5) begin n_err++; $display("FAIL data_rd: got %h expected %h", readdata, 32'hA5); end
  endtask

  task automatic test_set_clear_toggle();
    logic [2:0] addrs [3];
    logic [7:0] vals [3];
    logic [7:0] exp [3];
    addrs = '{3'd4, 3'd5, 3'd1};
    vals  = '{8'h0A, 8'h81, 8'hFF};
    exp   = '{8'hAF, 8'h2E, 8'hD1};
    for (int i = 0; i < 3; i++) begin
      wr(addrs[i], {24'h0, vals[i]});
      n_vec++; if (out_port !== exp[i]) begin n_err++; $display("FAIL sct_%0d: got %h expected %h", i, out_port, exp[i]); end
    end
  endtask

  task automatic test_pulse();
    wr(3'd0, 32'h0); wr(3'd2, 32'h1);
    wr(3'd3, 32'h3);
    n_vec++; if (out_port !== 8'h01) begin n_err++; $display("FAIL pulse_c1: got %h expected %h", out_port, 8'h01); end
    rd(3'd3);
    n_vec++; if (out_port !== 8'h01) begin n_err++; $display("FAIL pulse_c2: got %h expected %h", out_port, 8'h01); end
    n_vec++; if (readdata !== 32'h0001_0003) begin n_err++; $display("FAIL pulse_status: got %h expected %h", readdata, 32'h0001_0003); end
    idle();
    n_vec++; if (out_port !== 8'h01) begin n_err++; $display("FAIL pulse_c3: got %h expected %h", out_port, 8'h01); end
    idle();
    n_vec++; if (out_port !== 8'h00) begin n_err++; $display("FAIL pulse_end: got %h expected %h", out_port, 8'h00); end
    rd(3'd3);
    n_vec++; if (readdata !== 32'h0) begin n_err++; $display("FAIL pulse_idle_status: got %h expected %h", readdata, 32'h0); end
  endtask

  task automatic test_retrigger_abort();
    wr(3'd3, 32'h5);
    idle(); idle(); idle();  // REM now 2
    wr(3'd3, 32'h4);
    for (int i = 0; i < 4; i++) begin
      n_vec++; if (out_port !== 8'h01) begin n_err++; $display("FAIL retrig_c%0d: got %h expected %h", i, out_port, 8'h01); end
      idle();
    end
    n_vec++; if (out_port !== 8'h00) begin n_err++; $display("FAIL retrig_end: got %h expected %h", out_port, 8'h00); end
    wr(3'd3, 32'h5); idle();
    wr(3'd3, 32'h0);
    n_vec++; if (out_port !== 8'h00) begin n_err++; $display("FAIL abort_out: got %h expected %h", out_port, 8'h00); end
    rd(3'd3);
    n_vec++; if (readdata !== 32'h0) begin n_err++; $display("FAIL abort_status: got %h expected %h", readdata, 32'h0); end
  endtask

  task automatic test_data_during_pulse();
    wr(3'd2, 32'h0F); wr(3'd0, 32'h00);
    wr(3'd3, 32'd10);
    n_vec++; if (out_port !== 8'h0F) begin n_err++; $display("FAIL dp_c1: got %h expected %h", out_port, 8'h0F); end
    idle(); idle();
    wr(3'd0, 32'hF0);
    for (int i = 4; i <= 10; i++) begin
      n_vec++; if (out_port !== 8'hFF) begin n_err++; $display("FAIL dp_c%0d: got %h expected %h", i, out_port, 8'hFF); end
      idle();
    end
    n_vec++; if (out_port !== 8'hF0) begin n_err++; $display("FAIL dp_end: got %h expected %h", out_port, 8'hF0); end
  endtask

  task automatic test_reset_mid_pulse();
    wr(3'd0, 32'h00); wr(3'd2, 32'hFF);
    wr(3'd3, 32'd8); idle(); rd(3'd2);
    drive(1'b1, 1'b0, 1'b1, 3'd0, 32'h0);
    n_vec++; if (out_port !== RV) begin n_err++; $display("FAIL rmp_out: got %h expected %h", out_port, RV); end
    n_vec++; if (readdata !== 32'h0) begin n_err++; $display("FAIL rmp_rd: got %h expected %h", readdata, 32'h0); end
    rd(3'd3);
    n_vec++; if (readdata !== 32'h0) begin n_err++; $display("FAIL rmp_status: got %h expected %h", readdata, 32'h0); end
    n_vec++; if (out_port !== RV) begin n_err++; $display("FAIL rmp_out2: got %h expected %h", out_port, RV); end
  endtask

  task automatic test_random();
    logic        r, cs, wn;
    logic [2:0]  a;
    logic [31:0] d;
    for (int i = 0; i < 600; i++) begin
      r  = ($urandom_range(0, 59) == 0);
      cs = ($urandom_range(0, 3) != 0);
      wn = $urandom_range(0, 1) == 1;
      a  = 3'($urandom_range(0, 7));
      d  = $urandom;
      if (a == 3'd3 && $urandom_range(0, 3) != 0) d[15:0] = 16'($urandom_range(0, 7));
      drive(r, cs, wn, a, d);
      n_vec++; if (out_port !== m_out) begin n_err++; $display("FAIL rand_out[%0d]: got %h expected %h", i, out_port, m_out); end
      n_vec++; if (readdata !== m_rd) begin n_err++; $display("FAIL rand_rd[%0d]: got %h expected %h", i, readdata, m_rd); end
    end
  endtask

  initial begin
    test_reset();
    test_data_rw();
    test_set_clear_toggle();
    test_pulse();
    test_retrigger_abort();
    test_data_during_pulse();
    test_reset_mid_pulse();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/timersoc_gpio_out.md
TIMERSOC_GPIO_OUT -- requirements
Module: TimerSoC_GpioOut

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning the number of output pins (legal range 1..16).
REQ-002 SHALL have parameter RESET_VALUE, default 0, meaning the value loaded into the data register at reset.
REQ-003 SHALL have port clk  input  1  meaning the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  meaning a synchronous, active-high reset sampled on the rising edge of clk.
REQ-005 SHALL have port address  input  3  meaning the Avalon-MM slave word address.
REQ-006 SHALL have port chipselect  input  1  meaning the slave is selected this cycle.
REQ-007 SHALL have port write_n  input  1  meaning an active-low write strobe, qualified by chipselect.
REQ-008 SHALL have port writedata  input  32  meaning the write data.
REQ-009 SHALL have port readdata  output  32  meaning the registered read data.
REQ-010 SHALL have port out_port  output  WIDTH  meaning the registered pin drive.

Function
REQ-011 SHALL decode a write only when chipselect=1 and write_n=0, which is one write per cycle at most.
REQ-012 SHALL use this address map: 0 DATA (RW), 1 TOGGLE (W), 2 PMASK (RW), 3 PULSE (W; read returns status), 4 OUTSET (W), 5 OUTCLEAR (W), 6-7 reserved.
REQ-013 SHALL load DATA with writedata[WIDTH-1:0] on a write to address 0.
REQ-014 SHALL replace DATA with DATA XOR writedata[WIDTH-1:0] on a write to address 1.
REQ-015 SHALL replace DATA with DATA OR writedata[WIDTH-1:0] on a write to address 4, and with DATA AND NOT writedata[WIDTH-1:0] on a write to address 5.
REQ-016 SHALL load PMASK with writedata[WIDTH-1:0] on a write to address 2.
REQ-017 SHALL implement a two-state pulse FSM, IDLE and PULSING, with a 16-bit down-counter REM.
REQ-018 SHALL handle a write to address 3 with N=writedata[15:0] as follows: if N!=0, load REM=N and enter PULSING; if N=0, force IDLE and REM=0 (abort).
REQ-019 SHALL, in PULSING with no trigger write, decrement REM each cycle and enter IDLE on the edge at which REM goes 1->0.
REQ-020 SHALL give a trigger write during PULSING priority over the decrement and expiry, so REM reloads to N (retrigger).
REQ-021 SHALL register out_port each cycle as DATA_next XOR (PULSING_next ? PMASK_next : 0), so a register write is visible on out_port one cycle after the write edge.
REQ-022 SHALL therefore invert the PMASK bits on out_port for exactly N consecutive cycles after a trigger with N>=1, with no retrigger or abort in between.
REQ-023 SHALL apply DATA and PMASK writes made during PULSING on the next cycle, without altering REM.
REQ-024 SHALL register readdata one cycle after any cycle with chipselect=1 and write_n=1, returning pre-write register values when a read and a write coincide.
REQ-025 SHALL return these readdata values: address 0 = zero-extended DATA; address 2 = zero-extended PMASK; address 3 = {15'b0, busy, REM[15:0]}; addresses 1, 4, 5, 6 and 7 = 0.
REQ-026 SHALL hold readdata at its previous value when no read is in progress.
REQ-027 SHALL treat writes to addresses 6-7 as no effect.
REQ-028 SHALL ignore writedata bits above WIDTH-1 for addresses 0, 1, 2, 4 and 5.

Reset
REQ-029 SHALL, while reset=1 at a rising edge, set DATA=RESET_VALUE, PMASK=0, REM=0, FSM=IDLE, readdata=0 and out_port=RESET_VALUE.
REQ-030 SHALL let reset asserted mid-pulse terminate the pulse, so out_port equals RESET_VALUE on the following cycle.
REQ-031 SHALL make reset override any simultaneous write.

Verification
REQ-032 SHALL pass this scenario: reset; write addr0=0xA5 -> out_port=0xA5 one cycle later; read addr0 -> readdata=0x000000A5.
REQ-033 SHALL pass this scenario: DATA=0xA5; write addr4=0x0A, then addr5=0x81, then addr1=0xFF -> out_port sequence 0xAF, 0x2E, 0xD1.
REQ-034 SHALL pass this scenario: DATA=0x00, PMASK=0x01; write addr3=3 -> out_port=0x01 for exactly 3 cycles then 0x00; status read mid-pulse shows busy=1.
REQ-035 SHALL pass this scenario: pulse N=5; at REM=2, write addr3=4 -> pulse lasts 4 more cycles; separately, write addr3=0 mid-pulse -> out_port returns to DATA next cycle, status=0.
REQ-036 SHALL pass this scenario: pulse N=10 with PMASK=0x0F; at cycle 4 write addr0=0xF0 -> out_port=0xFF until expiry, then 0xF0.
REQ-037 SHALL pass this scenario: RESET_VALUE=0x3C; reset asserted mid-pulse -> out_port=0x3C, readdata=0, busy=0 after the reset edge.
